// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg
//   Shared definitions for the decode/issue stage:
//   - short-hand vector typedefs (i1/i5/i6/i16/i32)
//   - MIPS primary opcodes (icode) and SPECIAL funct codes (acode)
//   - small decode helpers shared by the stage and its sub-modules
package decode_issue_pkg;

    typedef logic        i1;
    typedef logic [4:0]  i5;
    typedef logic [5:0]  i6;
    typedef logic [15:0] i16;
    typedef logic [31:0] i32;

    // Primary opcodes (instr[31:26])
    localparam i6 OP_SPE   = 6'h00;
    localparam i6 OP_J     = 6'h02;
    localparam i6 OP_JAL   = 6'h03;
    localparam i6 OP_BEQ   = 6'h04;
    localparam i6 OP_BNE   = 6'h05;
    localparam i6 OP_ADDIU = 6'h09;
    localparam i6 OP_SLTI  = 6'h0A;
    localparam i6 OP_SLTIU = 6'h0B;
    localparam i6 OP_ANDI  = 6'h0C;
    localparam i6 OP_ORI   = 6'h0D;
    localparam i6 OP_XORI  = 6'h0E;
    localparam i6 OP_LUI   = 6'h0F;
    localparam i6 OP_LW    = 6'h23;
    localparam i6 OP_SW    = 6'h2B;

    // SPECIAL funct codes (instr[5:0])
    localparam i6 FN_SLL   = 6'h00;
    localparam i6 FN_SRL   = 6'h02;
    localparam i6 FN_SRA   = 6'h03;
    localparam i6 FN_JR    = 6'h08;

    // Constant-amount shifts take their amount from shamt, not from rs.
    function automatic i1 is_shift(input i6 fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

    // Immediate ALU ops whose imm16 is zero-extended (logical ops).
    function automatic i1 is_zext_op(input i6 op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/decode_issue_fwd_select.sv
// fwd_select
//   Operand selection for one register source.
//   Ports:
//     src_i        register index being read
//     rf_data_i    combinational regfile data for src_i
//     fwd_valid_i  per-stage: stage holds a register-writing instruction
//     fwd_dst_i    per-stage destination index (packed, stage 0 in LSBs)
//     fwd_val_i    per-stage result value (packed)
//     fwd_rdy_i    per-stage: result already available
//     value_o      selected operand value
//     hazard_o     selected producer has not produced its result yet
//   Stage 0 is the youngest and wins over older stages. Register 0 always
//   reads as zero and never matches a forwarding source.
module fwd_select
    import decode_issue_pkg::*;
#(
    parameter int NUM_FWD = 3,
    parameter int REG_AW  = 5,
    parameter int DATA_W  = 32
) (
    input  logic [REG_AW-1:0]         src_i,
    input  logic [DATA_W-1:0]         rf_data_i,
    input  logic [NUM_FWD-1:0]        fwd_valid_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_dst_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_val_i,
    input  logic [NUM_FWD-1:0]        fwd_rdy_i,
    output logic [DATA_W-1:0]         value_o,
    output logic                      hazard_o
);

    i1 found;

    always_comb begin
        found    = 1'b0;
        value_o  = rf_data_i;
        hazard_o = 1'b0;
        // Ascending scan with a sticky 'found' keeps the youngest match.
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!found && fwd_valid_i[i] &&
                (fwd_dst_i[i*REG_AW +: REG_AW] == src_i) &&
                (fwd_dst_i[i*REG_AW +: REG_AW] != '0)) begin
                found    = 1'b1;
                value_o  = fwd_val_i[i*DATA_W +: DATA_W];
                hazard_o = ~fwd_rdy_i[i];
            end
        end
        if (src_i == '0) begin
            value_o  = '0;
            hazard_o = 1'b0;
        end
    end

endmodule

// File: rtl/decode_issue.sv
// decode_issue
//   Decode/issue stage between fetch and execute of the MIPS pipeline.
//   Ports:
//     clk, reset                  clock, asynchronous active-high reset
//     in_valid/in_ready           fetch handshake
//     in_pc, in_instr             incoming PC and raw instruction
//     flush                       kill the held instruction
//     rf_raddr1/2, rf_rdata1/2    regfile read ports (rs, rt)
//     fwd_valid/dst/val/rdy       forwarding sources (0 = E, youngest)
//     out_valid/out_ready         execute handshake
//     out_pc, out_val1/2, out_valt issue operands (valt = store data)
//     out_icode, out_acode        opcode and funct
//     out_dst                     destination register (0 = none)
//     redirect_valid/redirect_pc  registered one-cycle branch/jump redirect
//     stall_cnt                   saturating count of hazard-stall cycles
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic [31:0]               in_instr,
    input  logic                      flush,
    output logic [REG_AW-1:0]         rf_raddr1,
    output logic [REG_AW-1:0]         rf_raddr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_dst,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_val,
    input  logic [NUM_FWD-1:0]        fwd_rdy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_pc,
    output logic [DATA_W-1:0]         out_val1,
    output logic [DATA_W-1:0]         out_val2,
    output logic [DATA_W-1:0]         out_valt,
    output logic [5:0]                out_icode,
    output logic [5:0]                out_acode,
    output logic [REG_AW-1:0]         out_dst,
    output logic                      redirect_valid,
    output logic [DATA_W-1:0]         redirect_pc,
    output logic [CNT_W-1:0]          stall_cnt
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    i1                 d_valid_q, d_valid_d;
    logic [DATA_W-1:0] d_pc_q, d_pc_d;
    i32                d_instr_q, d_instr_d;
    i1                 redirect_valid_q, redirect_valid_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    i6                 op, fn;
    logic [REG_AW-1:0] rs_idx, rt_idx, rd_idx;
    i16                imm;
    logic [25:0]       jidx;

    assign op     = d_instr_q[31:26];
    assign fn     = d_instr_q[5:0];
    assign rs_idx = REG_AW'(d_instr_q[25:21]);
    assign rt_idx = REG_AW'(d_instr_q[20:16]);
    assign rd_idx = REG_AW'(d_instr_q[15:11]);
    assign imm    = d_instr_q[15:0];
    assign jidx   = d_instr_q[25:0];

    assign rf_raddr1 = rs_idx;
    assign rf_raddr2 = rt_idx;

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] op1, op2;
    i1                 haz1, haz2;

    fwd_select #(
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW),
        .DATA_W  (DATA_W)
    ) u_sel_rs (
        .src_i       (rs_idx),
        .rf_data_i   (rf_rdata1),
        .fwd_valid_i (fwd_valid),
        .fwd_dst_i   (fwd_dst),
        .fwd_val_i   (fwd_val),
        .fwd_rdy_i   (fwd_rdy),
        .value_o     (op1),
        .hazard_o    (haz1)
    );

    fwd_select #(
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW),
        .DATA_W  (DATA_W)
    ) u_sel_rt (
        .src_i       (rt_idx),
        .rf_data_i   (rf_rdata2),
        .fwd_valid_i (fwd_valid),
        .fwd_dst_i   (fwd_dst),
        .fwd_val_i   (fwd_val),
        .fwd_rdy_i   (fwd_rdy),
        .value_o     (op2),
        .hazard_o    (haz2)
    );

    // ------------------------------------------------------------------
    // Immediates and targets
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] sext_imm, zext_imm, pc4, pc8, br_tgt, j_tgt;

    assign sext_imm = {{(DATA_W-16){imm[15]}}, imm};
    assign zext_imm = {{(DATA_W-16){1'b0}}, imm};
    assign pc4      = d_pc_q + DATA_W'(4);
    assign pc8      = d_pc_q + DATA_W'(8);
    assign br_tgt   = pc4 + (sext_imm << 2);
    assign j_tgt    = {pc4[DATA_W-1:28], jidx, 2'b00};

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    i1                 rs_used, rt_used, redir, taken;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] val1, val2, tgt;

    always_comb begin
        rs_used = 1'b1;
        rt_used = 1'b0;
        redir   = 1'b0;
        taken   = 1'b0;
        dst     = '0;
        val1    = op1;
        val2    = '0;
        tgt     = '0;
        case (op)
            OP_SPE: begin
                rt_used = 1'b1;
                dst     = rd_idx;
                val2    = op2;
                if (is_shift(fn)) begin
                    rs_used = 1'b0;
                    val1    = '0;
                end
                if (fn == FN_JR) begin
                    dst   = '0;
                    val2  = op1;
                    redir = 1'b1;
                    tgt   = op1;
                end
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dst  = rt_idx;
                val2 = is_zext_op(op) ? zext_imm : sext_imm;
            end
            OP_LUI: begin
                rs_used = 1'b0;
                dst     = rt_idx;
                val1    = '0;
                val2    = zext_imm << 16;
            end
            OP_LW: begin
                dst  = rt_idx;
                val2 = sext_imm;
            end
            OP_SW: begin
                rt_used = 1'b1;
                val2    = sext_imm;
            end
            OP_BEQ, OP_BNE: begin
                rt_used = 1'b1;
                taken   = (op == OP_BEQ) ? (op1 == op2) : (op1 != op2);
                val2    = taken ? br_tgt : '0;
                redir   = taken;
                tgt     = br_tgt;
            end
            OP_J: begin
                rs_used = 1'b0;
                val1    = '0;
                val2    = j_tgt;
                redir   = 1'b1;
                tgt     = j_tgt;
            end
            OP_JAL: begin
                rs_used = 1'b0;
                dst     = REG_AW'(31);
                val1    = pc8;
                val2    = j_tgt;
                redir   = 1'b1;
                tgt     = j_tgt;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    i1 hazard, issue;

    assign hazard    = (rs_used & haz1) | (rt_used & haz2);
    assign out_valid = d_valid_q & ~hazard;
    assign issue     = out_valid & out_ready;
    assign in_ready  = ~flush & (~d_valid_q | issue);

    assign out_pc    = d_pc_q;
    assign out_val1  = val1;
    assign out_val2  = val2;
    assign out_valt  = op2;
    assign out_icode = op;
    assign out_acode = fn;
    assign out_dst   = dst;

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall_cnt      = stall_cnt_q;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        d_valid_d        = d_valid_q;
        d_pc_d           = d_pc_q;
        d_instr_d        = d_instr_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        stall_cnt_d      = stall_cnt_q;

        if (flush) begin
            d_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            d_valid_d = 1'b1;
            d_pc_d    = in_pc;
            d_instr_d = in_instr;
        end else if (issue) begin
            d_valid_d = 1'b0;
        end

        // A flush in the issue cycle squashes the redirect too.
        if (issue && !flush && redir) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = tgt;
        end

        if (d_valid_q && hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_valid_q        <= 1'b0;
            d_pc_q           <= '0;
            d_instr_q        <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            stall_cnt_q      <= '0;
        end else begin
            d_valid_q        <= d_valid_d;
            d_pc_q           <= d_pc_d;
            d_instr_q        <= d_instr_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue
//   Directed scenarios followed by randomized traffic, all checked against
//   an instruction-level reference model of the decode/issue stage.
module tb_decode_issue;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NF = 3;
    localparam int CW = 4;   // narrow counter so saturation is reached

    localparam logic [5:0] T_SPE = 6'h00, T_J = 6'h02, T_JAL = 6'h03,
                           T_BEQ = 6'h04, T_BNE = 6'h05, T_ADDIU = 6'h09,
                           T_SLTI = 6'h0A, T_SLTIU = 6'h0B, T_ANDI = 6'h0C,
                           T_ORI = 6'h0D, T_XORI = 6'h0E, T_LUI = 6'h0F,
                           T_LW = 6'h23, T_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03,
                           F_JR = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23,
                           F_OR = 6'h25;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0]     in_pc;
    logic [31:0]       in_instr;
    logic [AW-1:0]     rf_raddr1, rf_raddr2, out_dst;
    logic [DW-1:0]     rf_rdata1, rf_rdata2;
    logic [NF-1:0]     fwd_valid, fwd_rdy;
    logic [NF*AW-1:0]  fwd_dst;
    logic [NF*DW-1:0]  fwd_val;
    logic [DW-1:0]     out_pc, out_val1, out_val2, out_valt, redirect_pc;
    logic [5:0]        out_icode, out_acode;
    logic              redirect_valid;
    logic [CW-1:0]     stall_cnt;

    logic [DW-1:0] regs [32];
    logic          fv [NF];
    logic [AW-1:0] fd [NF];
    logic [DW-1:0] fx [NF];
    logic          fr [NF];

    always #5 clk = ~clk;

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    always_comb begin
        for (int i = 0; i < NF; i++) begin
            fwd_valid[i]          = fv[i];
            fwd_rdy[i]            = fr[i];
            fwd_dst[i*AW +: AW]   = fd[i];
            fwd_val[i*DW +: DW]   = fx[i];
        end
    end

    decode_issue #(
        .DATA_W  (DW),
        .REG_AW  (AW),
        .NUM_FWD (NF),
        .CNT_W   (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_instr       (in_instr),
        .flush          (flush),
        .rf_raddr1      (rf_raddr1),
        .rf_raddr2      (rf_raddr2),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .fwd_valid      (fwd_valid),
        .fwd_dst        (fwd_dst),
        .fwd_val        (fwd_val),
        .fwd_rdy        (fwd_rdy),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_val1       (out_val1),
        .out_val2       (out_val2),
        .out_valt       (out_valt),
        .out_icode      (out_icode),
        .out_acode      (out_acode),
        .out_dst        (out_dst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_cnt      (stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one held instruction plus registered outputs
    // ------------------------------------------------------------------
    logic          m_valid, m_rv;
    logic [DW-1:0] m_pc, m_rpc;
    logic [31:0]   m_instr;
    int            m_cnt;

    logic          e_ov, e_ir, e_hazard, e_redir;
    logic [DW-1:0] e_v1, e_v2, e_vt, e_tgt;
    logic [AW-1:0] e_dst;

    function automatic logic [DW-1:0] operand(input logic [4:0] src, output logic haz);
        haz = 1'b0;
        if (src == 0) return '0;
        for (int i = 0; i < NF; i++)
            if (fv[i] && fd[i] == src) begin
                haz = !fr[i];
                return fx[i];
            end
        return regs[src];
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rv = 0; m_rpc = '0; m_cnt = 0; m_pc = '0; m_instr = '0;
    endtask

    task automatic eval_model();
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [DW-1:0] a, b, sx, pc4, bt, jt;
        logic h1, h2, use_rs, use_rt;
        op = m_instr[31:26]; rs = m_instr[25:21]; rt = m_instr[20:16];
        rd = m_instr[15:11]; fn = m_instr[5:0];   imm = m_instr[15:0];
        a   = operand(rs, h1);
        b   = operand(rt, h2);
        sx  = {{16{imm[15]}}, imm};
        pc4 = m_pc + 4;
        bt  = pc4 + sx * 4;
        jt  = {pc4[31:28], m_instr[25:0], 2'b00};
        use_rs = 1; use_rt = 0; e_dst = '0; e_v1 = a; e_v2 = '0; e_vt = b;
        e_redir = 0; e_tgt = '0;
        case (op)
            T_SPE: begin
                use_rt = 1; e_dst = rd; e_v2 = b;
                if (fn == F_SLL || fn == F_SRL || fn == F_SRA) begin
                    use_rs = 0; e_v1 = '0;
                end
                if (fn == F_JR) begin
                    e_dst = '0; e_v2 = a; e_redir = 1; e_tgt = a;
                end
            end
            T_ADDIU, T_SLTI, T_SLTIU, T_LW: begin e_dst = rt; e_v2 = sx; end
            T_ANDI, T_ORI, T_XORI:          begin e_dst = rt; e_v2 = {16'h0, imm}; end
            T_LUI: begin use_rs = 0; e_dst = rt; e_v1 = '0; e_v2 = {imm, 16'h0}; end
            T_SW:  begin use_rt = 1; e_v2 = sx; end
            T_BEQ, T_BNE: begin
                use_rt  = 1;
                e_redir = (op == T_BEQ) ? (a == b) : (a != b);
                e_v2    = e_redir ? bt : '0;
                e_tgt   = bt;
            end
            T_J:   begin use_rs = 0; e_v1 = '0; e_v2 = jt; e_redir = 1; e_tgt = jt; end
            T_JAL: begin
                use_rs = 0; e_dst = 31; e_v1 = m_pc + 8; e_v2 = jt;
                e_redir = 1; e_tgt = jt;
            end
            default: ;
        endcase
        e_hazard = (use_rs && h1) || (use_rt && h2);
        e_ov     = m_valid && !e_hazard;
        e_ir     = !flush && (!m_valid || (e_ov && out_ready));
    endtask

    // Called just after a falling edge with inputs driven; returns at the
    // next falling edge with the model advanced by one clock.
    task automatic run_cycle();
        logic issue;
        #1;
        eval_model();
        check("in_ready", in_ready, e_ir);
        check("out_valid", out_valid, e_ov);
        check("redirect_valid", redirect_valid, m_rv);
        if (m_rv) check("redirect_pc", redirect_pc, m_rpc);
        check("stall_cnt", stall_cnt, m_cnt);
        if (m_valid) begin
            check("rf_raddr1", rf_raddr1, m_instr[25:21]);
            check("rf_raddr2", rf_raddr2, m_instr[20:16]);
        end
        if (e_ov) begin
            check("out_pc", out_pc, m_pc);
            check("out_icode", out_icode, m_instr[31:26]);
            check("out_acode", out_acode, m_instr[5:0]);
            check("out_dst", out_dst, e_dst);
            check("out_val1", out_val1, e_v1);
            check("out_val2", out_val2, e_v2);
            if (m_instr[31:26] == T_SW) check("out_valt", out_valt, e_vt);
        end
        issue = e_ov && out_ready;
        @(posedge clk);
        m_rv = issue && !flush && e_redir;
        if (m_rv) m_rpc = e_tgt;
        if (m_valid && e_hazard && m_cnt != (2**CW - 1)) m_cnt++;
        if (flush) m_valid = 0;
        else if (in_valid && e_ir) begin
            m_valid = 1; m_pc = in_pc; m_instr = in_instr;
        end else if (issue) m_valid = 0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    task automatic no_fwd();
        for (int i = 0; i < NF; i++) begin
            fv[i] = 0; fd[i] = '0; fx[i] = '0; fr[i] = 1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  ops [10];
        logic [5:0]  fns [7];
        ops = '{T_ADDIU, T_SLTI, T_SLTIU, T_ANDI, T_ORI, T_XORI, T_LUI, T_LW, T_SW, T_BNE};
        fns = '{F_SLL, F_SRL, F_SRA, F_JR, F_ADDU, F_SUBU, F_OR};
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 5))
            0:       return {6'h00, rs, rt, rd, 5'($urandom), fns[$urandom_range(0, 6)]};
            1:       return itype(T_BEQ, rs, rt, imm);
            2:       return jtype(($urandom_range(0, 1) != 0) ? T_J : T_JAL, 26'($urandom));
            default: return itype(ops[$urandom_range(0, 9)], rs, rt, imm);
        endcase
    endfunction

    initial begin
        reset = 1; in_valid = 0; in_pc = '0; in_instr = '0; flush = 0; out_ready = 0;
        no_fwd();
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
        regs[0] = 32'hBAD0; regs[1] = 32'd7; regs[2] = 32'd7; regs[3] = 32'd8;
        model_reset();

        // Reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        reset = 0;

        // Back-to-back ADDIU r1,r0,5 / ADDU r2,r1,r1 with E forwarding
        out_ready = 1; in_valid = 1; in_pc = 32'h40; in_instr = itype(T_ADDIU, 0, 1, 16'd5);
        run_cycle();
        in_pc = 32'h44; in_instr = rtype(1, 1, 2, F_ADDU);
        #1 check("b2b_in_ready", in_ready, 1);
        run_cycle();
        in_valid = 0; fv[0] = 1; fd[0] = 1; fx[0] = 32'd5; fr[0] = 1;
        #1 check("fwd_out_valid", out_valid, 1);
        check("fwd_val1", out_val1, 32'd5);
        check("fwd_val2", out_val2, 32'd5);
        run_cycle();

        // Load-use: one stall cycle, then M supplies the value
        no_fwd(); in_valid = 1; in_pc = 32'h48; in_instr = rtype(3, 3, 5, F_ADDU);
        run_cycle();
        in_valid = 0; fv[0] = 1; fd[0] = 3; fx[0] = 32'h1234; fr[0] = 0;
        #1 check("lu_stall", out_valid, 0);
        run_cycle();
        fv[0] = 0; fv[1] = 1; fd[1] = 3; fx[1] = 32'hDEAD; fr[1] = 1;
        #1 check("lu_issue", out_valid, 1);
        check("lu_val1", out_val1, 32'hDEAD);
        check("lu_stall_cnt", stall_cnt, 1);
        run_cycle();

        // Priority E over W; r0 and dst 0 stay zero
        no_fwd(); in_valid = 1; in_instr = rtype(4, 0, 6, F_ADDU);
        run_cycle();
        in_valid = 0;
        fv[0] = 1; fd[0] = 4; fx[0] = 32'h11; fr[0] = 1;
        fv[2] = 1; fd[2] = 4; fx[2] = 32'h22; fr[2] = 1;
        fv[1] = 1; fd[1] = 0; fx[1] = 32'h99; fr[1] = 0;
        #1 check("prio_val1", out_val1, 32'h11);
        check("prio_r0_val2", out_val2, 0);
        check("prio_no_stall", out_valid, 1);
        run_cycle();

        // BEQ taken, then not taken
        no_fwd(); in_valid = 1; in_pc = 32'h100; in_instr = itype(T_BEQ, 1, 2, 16'h0004);
        run_cycle();
        in_valid = 0;
        #1 check("beq_val2", out_val2, 32'h114);
        check("beq_no_early_redirect", redirect_valid, 0);
        run_cycle();
        check("beq_redirect_valid", redirect_valid, 1);
        check("beq_redirect_pc", redirect_pc, 32'h114);
        in_valid = 1; in_pc = 32'h200; in_instr = itype(T_BEQ, 1, 3, 16'h0004);
        run_cycle();
        check("beq_redirect_one_cycle", redirect_valid, 0);
        in_valid = 0;
        #1 check("bne_path_val2", out_val2, 0);
        run_cycle();
        check("beq_nt_no_redirect", redirect_valid, 0);

        // JAL
        in_valid = 1; in_pc = 32'hBFC00000; in_instr = jtype(T_JAL, 26'h0000010);
        run_cycle();
        in_valid = 0;
        #1 check("jal_dst", out_dst, 31);
        check("jal_val1", out_val1, 32'hBFC00008);
        check("jal_val2", out_val2, 32'hB0000040);
        run_cycle();
        check("jal_redirect_valid", redirect_valid, 1);
        check("jal_redirect_pc", redirect_pc, 32'hB0000040);

        // J held for 3 cycles, then flushed in its issue cycle
        in_valid = 1; in_pc = 32'h2000; in_instr = jtype(T_J, 26'h0000123);
        run_cycle();
        in_pc = 32'h3000; in_instr = itype(T_ADDIU, 0, 7, 16'h1);
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1 check("hold_pc", out_pc, 32'h2000);
            check("hold_in_ready", in_ready, 0);
            run_cycle();
        end
        out_ready = 1; flush = 1;
        #1 check("flush_in_ready", in_ready, 0);
        run_cycle();
        flush = 0; in_valid = 0;
        check("flush_no_redirect", redirect_valid, 0);
        #1 check("flush_cleared", out_valid, 0);

        // Asynchronous reset in the middle of a stall
        in_valid = 1; in_pc = 32'h50; in_instr = rtype(3, 3, 5, F_ADDU);
        run_cycle();
        in_valid = 0; fv[0] = 1; fd[0] = 3; fr[0] = 0;
        run_cycle();
        #2 reset = 1;
        #1 check("areset_out_valid", out_valid, 0);
        check("areset_stall_cnt", stall_cnt, 0);
        model_reset();
        @(negedge clk);
        reset = 0; no_fwd();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pc     = $urandom & ~32'h3;
            in_instr  = rand_instr();
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NF; i++) begin
                fv[i] = ($urandom_range(0, 1) != 0);
                fd[i] = 5'($urandom_range(0, 7));
                fx[i] = $urandom;
                fr[i] = ($urandom_range(0, 3) != 0);
            end
            regs[$urandom_range(1, 7)] = $urandom;
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Parametrised decode/issue stage of the MIPS pipeline, sitting between fetch and execute.
- Holds a ready/valid decode register and reads the regfile through two ports.
- Forwards operands from NUM_FWD downstream stages, with youngest-first priority.
- Stalls on producers whose value is not ready yet (load-use), resolves BEQ/BNE/J/JAL/JR and emits a registered redirect.
- Supports flush and keeps a saturating stall counter.

Parameters:
- DATA_W, 32, datapath and PC width.
- REG_AW, 5, register index width (2**REG_AW registers; index 0 reads as zero).
- NUM_FWD, 3, forwarding sources; index 0 is the youngest (E), then M, then W.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode register can accept.
- in_pc  in  DATA_W  PC of the instruction.
- in_instr  in  32  raw instruction.
- flush  in  1  kill the held instruction.
- rf_raddr1, rf_raddr2  out  REG_AW  regfile read indices (rs, rt).
- rf_rdata1, rf_rdata2  in  DATA_W  combinational regfile data.
- fwd_valid  in  NUM_FWD  stage holds a register-writing instruction.
- fwd_dst  in  NUM_FWD*REG_AW  destination per stage.
- fwd_val  in  NUM_FWD*DATA_W  result per stage.
- fwd_rdy  in  NUM_FWD  result already available (0 for a load still in E/M).
- out_valid  out  1  issue to execute.
- out_ready  in  1  execute accepts.
- out_pc, out_val1, out_val2, out_valt  out  DATA_W  operands; valt is the store data.
- out_icode, out_acode  out  6  opcode and funct.
- out_dst  out  REG_AW  destination register (0 = none).
- redirect_valid  out  1  one-cycle pulse.
- redirect_pc  out  DATA_W  branch/jump target.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (async): d_valid=0, redirect_valid=0, redirect_pc=0, stall_cnt=0. Combinational outputs are therefore out_valid=0 and in_ready=1.
- Decode register: loads {in_pc, in_instr} on in_valid&in_ready.
  - in_ready = ~flush & (~d_valid | (out_valid&out_ready)).
  - Zero bubbles at full throughput.
- flush: clears d_valid next edge and blocks acceptance that cycle. flush beats a simultaneous issue: no redirect is generated.
- Operand select, per source (rs, rt):
  - index 0 gives 0.
  - Otherwise the lowest-index i with fwd_valid[i] & fwd_dst[i]==src & fwd_dst[i]!=0 is chosen.
  - Else the regfile value is used.
  - If the chosen i has fwd_rdy[i]=0, the source is a hazard.
- Sources actually used:
  - rs: all ops except J, JAL, LUI, SLL/SRL/SRA.
  - rt: SPE R-type, BEQ, BNE, SW.
  - An unused source never stalls.
- out_valid = d_valid & ~hazard.
- stall_cnt increments on each cycle with d_valid & hazard, and saturates at all-ones.
- Destination field: R-type gives rd (JR gives 0); immediate ALU ops, LUI and LW give rt; JAL gives 31; others give 0.
- val1: rs operand. J and LUI give 0. JAL gives pc+8. Shifts give 0.
- val2:
  - immediate ops: zero- or sign-extended imm16, by op.
  - LUI: imm16<<16.
  - LW/SW: sign-extended offset.
  - R-type: rt operand.
  - JR: rs operand.
  - J/JAL: jump target.
  - branches: taken target, or 0.
- Targets:
  - branch target = pc+4 + (sext(imm16)<<2), wrapping mod 2**DATA_W.
  - jump target = {(pc+4)[DATA_W-1:28], idx26, 2'b00}.
- Redirect:
  - Registered; on the edge after an issue (out_valid&out_ready) of J, JAL, JR or a taken BEQ/BNE, redirect_valid=1 for exactly one cycle.
  - Branch comparison uses the forwarded operands.
  - The delay slot is not killed.
- Held state is stable while out_ready=0.
- Reset mid-stall discards the held instruction.

Decomposition:
- Shared package: icode/acode constants (SPE, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE, J, JAL, JR, SLL, SRL, SRA), and the i1/i5/i6/i16/i32 typedefs.
- Sub-module fwd_select: one instance per source. It is parametrised by NUM_FWD/REG_AW/DATA_W and outputs {value, hazard}.

Test Plan:
- Back-to-back ADDIU r1,r0,5 and ADDU r2,r1,r1, with stage E reporting fwd_dst=1, val=5, rdy=1 -> no stall; out_val1=out_val2=5.
- Load-use: held ADDU reads r3, E has fwd_dst=3, rdy=0 for 1 cycle -> out_valid=0 for 1 cycle and stall_cnt=1. Next cycle, with M providing 0xDEAD rdy=1 -> issues with val1=0xDEAD.
- Priority: E and W both target r4 (0x11, 0x22), all ready -> operand=0x11. Reading r0 with fwd_dst=0 gives 0.
- BEQ at pc=0x100, imm=0x0004, operands equal, issued -> redirect_valid=1 for one cycle on the following edge, redirect_pc=0x114. With unequal operands -> no redirect, val2=0.
- JAL at pc=0xBFC00000, idx=0x0000010 -> out_dst=31, val1=0xBFC00008, redirect_pc=0xB0000040.
- flush asserted together with issue of J, and out_ready=0 for 3 cycles before it -> outputs held stable; on flush, d_valid clears with no redirect. Async reset mid-stall -> out_valid=0 immediately.
